// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath/instruction-memory signal bundle for the multi-cycle MIPS controller.
// The master side is the controller; the slave side is the datapath and fetch memory.
interface mips_multicycle_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] alu_result;
  logic [31:0] I;
  logic [2:0]  opcode;
  logic        RegW;
  logic        Regdst;
  logic        ALUSrc;
  logic        MemR;
  logic        MemW;
  logic        MemtoReg;
  logic        halted;
  logic        retire;

  modport master (
    output imem_req, imem_addr, I, opcode, RegW, Regdst, ALUSrc,
           MemR, MemW, MemtoReg, halted, retire,
    input  imem_ack, imem_rdata, alu_result
  );

  modport slave (
    input  imem_req, imem_addr, I, opcode, RegW, Regdst, ALUSrc,
           MemR, MemW, MemtoReg, halted, retire,
    output imem_ack, imem_rdata, alu_result
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: owns PC and IR, fetches over req/ack, decodes and
// sequences the datapath one phase per state; branches resolve from alu_result.
module mips_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [2:0]  ALU_ADD  = 3'b000,
  parameter logic [2:0]  ALU_SUB  = 3'b001,
  parameter logic [2:0]  ALU_AND  = 3'b010,
  parameter logic [2:0]  ALU_OR   = 3'b011,
  parameter logic [2:0]  ALU_SLT  = 3'b100
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ADDI = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_J    = 3'd5,
    CLS_ILL  = 3'd6
  } cls_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] ir_r, ir_s;

  cls_t        cls_s;
  logic [2:0]  alu_op_s;
  logic        regdst_s;
  logic        alusrc_s;
  logic        memtoreg_s;
  logic [4:0]  dest_s;
  logic [31:0] br_off_s;

  logic        imem_req_s;
  logic        reg_w_s;
  logic        mem_r_s;
  logic        mem_w_s;
  logic        retire_s;

  // Instruction decode: class, ALU op and datapath selects straight from the IR
  always_comb begin
    cls_s      = CLS_ILL;
    alu_op_s   = ALU_ADD;
    regdst_s   = 1'b0;
    alusrc_s   = 1'b0;
    memtoreg_s = 1'b0;
    case (ir_r[31:26])
      6'b000000: begin
        cls_s      = CLS_R;
        alusrc_s   = 1'b1;
        memtoreg_s = 1'b1;
        case (ir_r[5:0])
          6'b100000: alu_op_s = ALU_ADD;
          6'b100010: alu_op_s = ALU_SUB;
          6'b100100: alu_op_s = ALU_AND;
          6'b100101: alu_op_s = ALU_OR;
          6'b101010: alu_op_s = ALU_SLT;
          default:   cls_s    = CLS_ILL;
        endcase
      end
      6'b001000: begin
        cls_s      = CLS_ADDI;
        regdst_s   = 1'b1;
        memtoreg_s = 1'b1;
      end
      6'b100011: begin
        cls_s    = CLS_LW;
        regdst_s = 1'b1;
      end
      6'b101011: cls_s = CLS_SW;
      6'b000100: begin
        cls_s    = CLS_BEQ;
        alusrc_s = 1'b1;
        alu_op_s = ALU_SUB;
      end
      6'b000010: cls_s = CLS_J;
      default:   cls_s = CLS_ILL;
    endcase
  end

  assign dest_s   = regdst_s ? ir_r[20:16] : ir_r[15:11];
  assign br_off_s = {{14{ir_r[15]}}, ir_r[15:0], 2'b00};

  // Next-state, PC/IR update and state-gated strobes
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    ir_s       = ir_r;
    imem_req_s = 1'b0;
    reg_w_s    = 1'b0;
    mem_r_s    = 1'b0;
    mem_w_s    = 1'b0;
    retire_s   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (bus.imem_ack) begin
          ir_s    = bus.imem_rdata;
          pc_s    = pc_r + 32'd4;
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (cls_s)
          CLS_J: begin
            pc_s     = {pc_r[31:28], ir_r[25:0], 2'b00};
            retire_s = 1'b1;
            state_s  = ST_FETCH;
          end
          CLS_ILL: state_s = ST_HALT;
          default: state_s = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_s)
          CLS_LW, CLS_SW: state_s = ST_MEM;
          CLS_BEQ: begin
            if (bus.alu_result == 32'd0) begin
              pc_s = pc_r + br_off_s;
            end else begin
              pc_s = pc_r;
            end
            retire_s = 1'b1;
            state_s  = ST_FETCH;
          end
          default: state_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (cls_s == CLS_LW) begin
          mem_r_s = 1'b1;
          state_s = ST_WB;
        end else begin
          mem_w_s  = 1'b1;
          retire_s = 1'b1;
          state_s  = ST_FETCH;
        end
      end
      ST_WB: begin
        reg_w_s  = (dest_s != 5'd0);
        mem_r_s  = (cls_s == CLS_LW);
        retire_s = 1'b1;
        state_s  = ST_FETCH;
      end
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_FETCH;
    endcase
  end

  // State, PC and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      ir_r    <= 32'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
    end
  end

  // Strobes are masked while reset is high so nothing fires in an abandoned phase
  assign bus.imem_req  = imem_req_s & ~rst;
  assign bus.RegW      = reg_w_s & ~rst;
  assign bus.MemR      = mem_r_s & ~rst;
  assign bus.MemW      = mem_w_s & ~rst;
  assign bus.retire    = retire_s & ~rst;
  assign bus.halted    = (state_r == ST_HALT) & ~rst;
  assign bus.imem_addr = pc_r;
  assign bus.I         = ir_r;
  assign bus.opcode    = alu_op_s;
  assign bus.Regdst    = regdst_s;
  assign bus.ALUSrc    = alusrc_s;
  assign bus.MemtoReg  = memtoreg_s;

endmodule
